// File: rtl/snn_layer_sequencer_pkg.sv
// Shared types and sizing helpers for the SNN layer sequencer.
package snn_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPUTE = 3'd1,
    STEP    = 3'd2,
    TSTEP   = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

  typedef enum logic {
    FIRST_SPIKE = 1'b0,
    RATE        = 1'b1
  } seq_mode_t;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/snn_layer_sequencer_if.sv
// Control/result bundle between the network controller, the sequencer and the neuron array.
interface snn_layer_sequencer_if
  import snn_seq_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int CNT_W       = 8,
  parameter int IDX_W       = clog2_min1(NUM_NEURONS)
);
  logic                         start;
  logic                         mode;
  logic                         ack;
  logic [NUM_NEURONS-1:0]       neuron_valid;
  logic [NUM_NEURONS-1:0]       neuron_fired;
  logic [NUM_NEURONS-1:0]       neuron_enables;
  logic                         busy;
  logic                         step_done;
  logic                         timestep_done;
  logic                         layer_valid;
  logic                         timeout_err;
  logic [NUM_NEURONS-1:0]       spike_vector;
  logic [NUM_NEURONS*CNT_W-1:0] spike_counts;
  logic [IDX_W-1:0]             winner_idx;

  modport master (
    output start, mode, ack, neuron_valid, neuron_fired,
    input  neuron_enables, busy, step_done, timestep_done, layer_valid,
           timeout_err, spike_vector, spike_counts, winner_idx
  );

  modport slave (
    input  start, mode, ack, neuron_valid, neuron_fired,
    output neuron_enables, busy, step_done, timestep_done, layer_valid,
           timeout_err, spike_vector, spike_counts, winner_idx
  );
endinterface

// File: rtl/snn_layer_sequencer_argmax.sv
// Combinational argmax over packed counts; ties resolve to the lowest index.
module spike_argmax
  import snn_seq_pkg::*;
#(
  parameter int N     = 10,
  parameter int W     = 8,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N*W-1:0]  values,
  output logic [IDX_W-1:0] idx
);
  logic [W-1:0] best;

  always_comb begin
    idx  = '0;
    best = values[W-1:0];
    // Strict compare keeps the earlier index on equal counts.
    for (int i = 1; i < N; i++) begin
      if (values[i*W +: W] > best) begin
        best = values[i*W +: W];
        idx  = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/snn_layer_sequencer.sv
// Steps a LIF layer through pixels and timesteps, gating neuron enables and collecting spikes.
module snn_layer_sequencer
  import snn_seq_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int IMAGE_SIZE  = 784,
  parameter int NUM_STEPS   = 1,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 1024
) (
  input logic                  clk,
  input logic                  rst,
  snn_layer_sequencer_if.slave bus
);
  localparam int IDX_W = clog2_min1(NUM_NEURONS);
  localparam int PIX_W = clog2_min1(IMAGE_SIZE);
  localparam int T_W   = clog2_min1(NUM_STEPS);
  localparam int WD_W  = clog2_min1(TIMEOUT);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMAGE_SIZE - 1);
  localparam logic [T_W-1:0]   T_LAST   = T_W'(NUM_STEPS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  seq_state_t state_reg, state_next;
  seq_mode_t  mode_reg;

  logic [NUM_NEURONS-1:0] active_reg, active_next;
  logic [NUM_NEURONS-1:0] done_latch_reg;
  logic [NUM_NEURONS-1:0] spike_vector_reg;
  logic [NUM_NEURONS-1:0] enables, hs, hit;
  logic [PIX_W-1:0]       pixel_cnt_reg;
  logic [T_W-1:0]         t_cnt_reg;
  logic [WD_W-1:0]        wd_cnt_reg;
  logic                   timeout_reg;
  logic [IDX_W-1:0]       winner_reg, winner_next;
  logic [NUM_NEURONS*CNT_W-1:0] counts_flat, counts_next_flat;

  logic accept_start, ready, wd_expire, all_retired;

  assign accept_start = (state_reg == IDLE) && bus.start;
  assign enables      = (state_reg == COMPUTE) ? (active_reg & ~done_latch_reg) : '0;
  assign hs           = bus.neuron_valid & enables;
  assign hit          = hs & bus.neuron_fired;
  assign ready        = &(done_latch_reg | hs | ~active_reg);
  assign wd_expire    = !ready && (wd_cnt_reg == WD_LAST);
  assign active_next  = (mode_reg == FIRST_SPIKE) ? (active_reg & ~hit) : active_reg;
  assign all_retired  = (mode_reg == FIRST_SPIKE) && (active_next == '0);

  // Per-neuron saturating spike counters.
  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : gen_neuron
    logic [CNT_W-1:0] count_reg, count_next;

    always_comb begin
      count_next = count_reg;
      if (hit[gi] && (count_reg != {CNT_W{1'b1}}))
        count_next = count_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst || accept_start)
        count_reg <= '0;
      else if (state_reg == COMPUTE)
        count_reg <= count_next;
    end

    assign counts_flat[gi*CNT_W +: CNT_W]      = count_reg;
    assign counts_next_flat[gi*CNT_W +: CNT_W] = count_next;
  end

  // Argmax sees the post-update counts so the winner reflects the final fire.
  spike_argmax #(.N(NUM_NEURONS), .W(CNT_W), .IDX_W(IDX_W)) u_argmax (
    .values (counts_next_flat),
    .idx    (winner_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = COMPUTE;
      COMPUTE: begin
        if (wd_expire)                   state_next = DONE;
        else if (ready) begin
          if (all_retired)               state_next = DONE;
          else if (pixel_cnt_reg != PIX_LAST) state_next = STEP;
          else if (t_cnt_reg != T_LAST)  state_next = TSTEP;
          else                           state_next = DONE;
        end
      end
      STEP, TSTEP: state_next = COMPUTE;
      DONE:    if (bus.ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy          = (state_reg != IDLE);
    bus.step_done     = (state_reg == STEP);
    bus.timestep_done = (state_reg == TSTEP);
    bus.layer_valid   = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg         <= FIRST_SPIKE;
      active_reg       <= '1;
      done_latch_reg   <= '0;
      spike_vector_reg <= '0;
      pixel_cnt_reg    <= '0;
      t_cnt_reg        <= '0;
      wd_cnt_reg       <= '0;
      timeout_reg      <= 1'b0;
      winner_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: if (bus.start) begin
          mode_reg         <= seq_mode_t'(bus.mode);
          active_reg       <= '1;
          done_latch_reg   <= '0;
          spike_vector_reg <= '0;
          pixel_cnt_reg    <= '0;
          t_cnt_reg        <= '0;
          wd_cnt_reg       <= '0;
          timeout_reg      <= 1'b0;
        end
        COMPUTE: begin
          done_latch_reg   <= done_latch_reg | hs;
          spike_vector_reg <= spike_vector_reg | hit;
          active_reg       <= active_next;
          wd_cnt_reg       <= wd_cnt_reg + 1'b1;
          if (wd_expire) timeout_reg <= 1'b1;
        end
        STEP: begin
          pixel_cnt_reg  <= pixel_cnt_reg + 1'b1;
          done_latch_reg <= '0;
          wd_cnt_reg     <= '0;
        end
        TSTEP: begin
          pixel_cnt_reg  <= '0;
          t_cnt_reg      <= t_cnt_reg + 1'b1;
          done_latch_reg <= '0;
          wd_cnt_reg     <= '0;
        end
        default: ;
      endcase
      if ((state_next == DONE) && (state_reg != DONE))
        winner_reg <= winner_next;
    end
  end

  assign bus.neuron_enables = enables;
  assign bus.timeout_err    = timeout_reg;
  assign bus.spike_vector   = spike_vector_reg;
  assign bus.spike_counts   = counts_flat;
  assign bus.winner_idx     = winner_reg;
endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Randomized bench: per-pixel valid/fire schedules checked against a pixel-level reference model.
module tb_snn_layer_sequencer;
  import snn_seq_pkg::*;

  localparam int N     = 4;
  localparam int IMG   = 5;
  localparam int STEPS = 2;
  localparam int CW    = 3;
  localparam int TO    = 8;
  localparam int IW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snn_layer_sequencer_if #(.NUM_NEURONS(N), .CNT_W(CW), .IDX_W(IW)) bus ();

  snn_layer_sequencer #(
    .NUM_NEURONS(N), .IMAGE_SIZE(IMG), .NUM_STEPS(STEPS), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_results(input string tag, input int cnt[N], input logic [N-1:0] sv);
    int best, win;
    best = -1;
    win  = 0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_count%0d", tag, i), 32'(bus.spike_counts[i*CW +: CW]), 32'(cnt[i]));
      if (cnt[i] > best) begin
        best = cnt[i];
        win  = i;
      end
    end
    chk({tag, "_spike_vector"}, 32'(bus.spike_vector), 32'(sv));
    chk({tag, "_winner"}, 32'(bus.winner_idx), 32'(win));
  endtask

  // One full inference: start, per-pixel schedules, DONE hold, ack.
  task automatic run_inference(input bit m, input int fire_pct, input bit hang);
    int cnt[N];
    int d[N];
    bit f[N];
    logic [N-1:0] act, sv, exp_en;
    int maxd, len, n_step, n_tstep;
    bit done, to;

    act = '1; sv = '0; to = 0; done = 0; n_step = 0; n_tstep = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;

    bus.start = 1'b1;
    bus.mode  = m;
    tick();
    bus.start = 1'b0;
    chk("timeout_cleared", 32'(bus.timeout_err), 0);

    for (int t = 0; t < STEPS; t++) begin
      for (int p = 0; p < IMG; p++) begin
        if (!done) begin
          maxd = 0;
          for (int i = 0; i < N; i++) begin
            d[i] = $urandom_range(0, 3);
            f[i] = ($urandom_range(0, 99) < fire_pct);
            if (hang && t == 0 && p == 0 && i == 0) d[i] = 1000;
            if (act[i] && d[i] > maxd) maxd = d[i];
          end
          len = maxd + 1;
          if (len > TO) begin
            len = TO;
            to  = 1;
          end
          for (int k = 0; k < len; k++) begin
            for (int i = 0; i < N; i++) exp_en[i] = act[i] && (k <= d[i]);
            chk("enables", 32'(bus.neuron_enables), 32'(exp_en));
            chk("busy_compute", 32'(bus.busy), 1);
            chk("no_pulse_compute", {30'd0, bus.step_done, bus.timestep_done}, 0);
            for (int i = 0; i < N; i++) begin
              bus.neuron_valid[i] = (k >= d[i]);
              bus.neuron_fired[i] = (k >= d[i]) ? f[i] : 1'($urandom_range(0, 1));
            end
            bus.start = 1'($urandom_range(0, 1));
            bus.ack   = 1'($urandom_range(0, 1));
            tick();
          end
          bus.neuron_valid = '0;
          bus.neuron_fired = '0;
          bus.start = 1'b0;
          bus.ack   = 1'b0;
          for (int i = 0; i < N; i++) begin
            if (act[i] && d[i] < len && f[i]) begin
              if (cnt[i] < CMAX) cnt[i]++;
              sv[i] = 1'b1;
              if (!m) act[i] = 1'b0;
            end
          end
          if (to || (!m && act == '0) || (p == IMG - 1 && t == STEPS - 1)) begin
            done = 1;
          end else if (p != IMG - 1) begin
            chk("step_done", {30'd0, bus.step_done, bus.timestep_done}, 2);
            chk("enables_step", 32'(bus.neuron_enables), 0);
            n_step++;
            tick();
          end else begin
            chk("timestep_done", {30'd0, bus.step_done, bus.timestep_done}, 1);
            n_tstep++;
            tick();
          end
        end
      end
    end

    chk("layer_valid", 32'(bus.layer_valid), 1);
    chk("done_no_pulse", {30'd0, bus.step_done, bus.timestep_done}, 0);
    chk("timeout_err", 32'(bus.timeout_err), 32'(to));
    chk_results("done", cnt, sv);
    $display("inference mode=%0d fire_pct=%0d hang=%0d steps=%0d tsteps=%0d timeout=%0d sv=%b",
             m, fire_pct, hang, n_step, n_tstep, to, sv);

    bus.start = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    chk("done_holds", 32'(bus.layer_valid), 1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("idle_after_ack", {30'd0, bus.busy, bus.layer_valid}, 0);
    chk_results("idle_hold", cnt, sv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.ack = 1'b0;
    bus.neuron_valid = '0; bus.neuron_fired = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_enables", 32'(bus.neuron_enables), 0);
    chk("rst_counts", 32'(bus.spike_counts), 0);
    chk("rst_flags", {27'd0, bus.step_done, bus.timestep_done, bus.layer_valid,
                      bus.timeout_err, 1'b0}, 0);
    chk("rst_winner", 32'(bus.winner_idx), 0);
    rst = 1'b0;
    tick();

    run_inference(1'b0, 100, 1'b0);
    run_inference(1'b1, 100, 1'b0);
    run_inference(1'b0, 0, 1'b1);
    run_inference(1'b1, 50, 1'b1);
    for (int r = 0; r < 6; r++) run_inference(1'b1, 35, 1'b0);
    for (int r = 0; r < 6; r++) run_inference(1'b0, 20, 1'b0);
    run_inference(1'b1, 60, 1'b1);

    bus.start = 1'b1;
    bus.mode  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.neuron_valid = 4'b0011;
    bus.neuron_fired = 4'b0011;
    tick();
    bus.neuron_valid = '0;
    bus.neuron_fired = '0;
    chk("pre_rst_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_enables", 32'(bus.neuron_enables), 0);
    chk("midrst_counts", 32'(bus.spike_counts), 0);
    chk("midrst_sv", 32'(bus.spike_vector), 0);
    chk("midrst_winner", 32'(bus.winner_idx), 0);
    chk("midrst_timeout", 32'(bus.timeout_err), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {30'd0, bus.busy, bus.layer_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
